mouse_step_scheduler: RTL

- Shares the Jaguar mouse-port quadrature outputs between two pointer sources: req0 is the PS/2 mouse packet decoder and req1 is the gamepad/keyboard pointer emulation.
- Accepts signed delta packets through a round-robin valid/ready arbiter and accumulates them per axis with saturation.
- Schedules quadrature steps at a programmable rate, alternating X and Y when both axes have steps pending.
- Sits between the input decoders and the mouse-port pins.

---
 rtl/mouse_pkg.sv | 14 +
 rtl/mouse_step_scheduler_quad_phase.sv | 27 ++
 rtl/mouse_step_scheduler.sv | 111 +++++++++++
 3 files changed

// File: rtl/mouse_pkg.sv
// Shared constants for the mouse-port step scheduler: quadrature phases,
// button bit positions and the default step threshold.
package mouse_pkg;
  localparam int THRESH_DEF = 16;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b10;
  localparam logic [1:0] Q2 = 2'b11;
  localparam logic [1:0] Q3 = 2'b01;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
endpackage

// File: rtl/mouse_step_scheduler_quad_phase.sv
// 2-bit Gray-code quadrature stepper: advances one phase per step,
// forward (Q0->Q1->Q2->Q3) when dir=1, backward otherwise.
module quad_phase
  import mouse_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       dir,
  output logic [1:0] q
);
  logic [1:0] nxt;

  always_comb begin
    nxt = q;
    case (q)
      Q0:      nxt = dir ? Q1 : Q3;
      Q1:      nxt = dir ? Q2 : Q0;
      Q2:      nxt = dir ? Q3 : Q1;
      default: nxt = dir ? Q0 : Q2;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)     q <= Q0;
    else if (step) q <= nxt;
endmodule

// File: rtl/mouse_step_scheduler.sv
// Two-source pointer delta arbiter feeding saturating per-axis accumulators
// that are drained into quadrature steps at a programmable rate.
module mouse_step_scheduler
  import mouse_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int ACC_W  = 12,
  parameter int THRESH = THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [DIV_W-1:0]  period,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic signed [8:0] req0_dx,
  input  logic signed [8:0] req0_dy,
  input  logic [2:0]        req0_btn,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic signed [8:0] req1_dx,
  input  logic signed [8:0] req1_dy,
  input  logic [2:0]        req1_btn,
  output logic [1:0]        xout,
  output logic [1:0]        yout,
  output logic              button_l,
  output logic              button_r,
  output logic              button_m,
  output logic              busy
);
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (ACC_W-1)) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV;
  localparam logic signed [SW-1:0] TH   = SW'(THRESH);

  logic                    rr, last_was_x;
  logic [DIV_W-1:0]        cnt, pmax;
  logic signed [ACC_W-1:0] xacc, yacc;
  logic signed [SW-1:0]    xw, yw, xadj, yadj, dxw, dyw, xsum, ysum;
  logic [2:0]              btn0, btn1, btn0_n, btn1_n;
  logic signed [8:0]       dx_sel, dy_sel;
  logic                    acc0, acc1, tick, px, py, step_x, step_y;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAXV)      return MAXV[ACC_W-1:0];
    else if (v < MINV) return MINV[ACC_W-1:0];
    else               return v[ACC_W-1:0];
  endfunction

  assign req0_ready = req0_valid & (~req1_valid | ~rr);
  assign req1_ready = req1_valid & (~req0_valid | rr);
  assign acc0       = req0_ready;
  assign acc1       = req1_ready;

  assign dx_sel = acc0 ? req0_dx : (acc1 ? req1_dx : '0);
  assign dy_sel = acc0 ? req0_dy : (acc1 ? req1_dy : '0);
  assign dxw    = {{(SW-9){dx_sel[8]}}, dx_sel};
  assign dyw    = {{(SW-9){dy_sel[8]}}, dy_sel};
  assign btn0_n = acc0 ? req0_btn : btn0;
  assign btn1_n = acc1 ? req1_btn : btn1;

  // period 0 behaves as 1: compare against 0 so every ce ticks
  assign pmax = (period == '0) ? '0 : period - 1'b1;
  assign tick = ce & (cnt >= pmax);

  assign xw   = {{2{xacc[ACC_W-1]}}, xacc};
  assign yw   = {{2{yacc[ACC_W-1]}}, yacc};
  assign px   = (xw >= TH) || (xw <= -TH);
  assign py   = (yw >= TH) || (yw <= -TH);
  assign busy = px | py;

  assign step_x = tick & px & (~py | ~last_was_x);
  assign step_y = tick & py & (~px | last_was_x);

  // direction comes from the live sign, so reversals need no stored state
  assign xadj = step_x ? (xacc[ACC_W-1] ? -TH : TH) : '0;
  assign yadj = step_y ? (yacc[ACC_W-1] ? -TH : TH) : '0;
  assign xsum = xw - xadj + dxw;
  assign ysum = yw - yadj + dyw;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr         <= 1'b0;
      last_was_x <= 1'b0;
      cnt        <= '0;
      xacc       <= '0;
      yacc       <= '0;
      btn0       <= '0;
      btn1       <= '0;
      button_l   <= 1'b1;
      button_r   <= 1'b1;
      button_m   <= 1'b1;
    end else begin
      if (acc0)      rr <= 1'b1;
      else if (acc1) rr <= 1'b0;
      if (tick)      cnt <= '0;
      else if (ce)   cnt <= cnt + 1'b1;
      if (step_x)      last_was_x <= 1'b1;
      else if (step_y) last_was_x <= 1'b0;
      xacc     <= sat(xsum);
      yacc     <= sat(ysum);
      btn0     <= btn0_n;
      btn1     <= btn1_n;
      button_l <= ~(btn0_n[BTN_L] | btn1_n[BTN_L]);
      button_r <= ~(btn0_n[BTN_R] | btn1_n[BTN_R]);
      button_m <= ~(btn0_n[BTN_M] | btn1_n[BTN_M]);
    end

  quad_phase u_qx (.clk(clk), .reset(reset), .step(step_x), .dir(~xacc[ACC_W-1]), .q(xout));
  quad_phase u_qy (.clk(clk), .reset(reset), .step(step_y), .dir(~yacc[ACC_W-1]), .q(yout));
endmodule
